screen_sequencer: RTL
=====================

# screen_sequencer

Game-phase controller that drives the VGA screen-mode inputs (`logo`, `get_ready`, `times_up`, `leaderboard`) and feeds the score display with a 4-digit BCD score. It runs on the VGA pixel clock and changes phase only at frame boundaries, so no frame ever shows two screens. It replaces the free-running opening-screen counter, keeps the best score with its house for the leaderboard, and sits between the button/wand logic and `vga_controller`.

## Interface
- `LOGO_FRAMES`, 300, frames the opening logo is shown (1..4095)
- `READY_FRAMES`, 180, frames of the "get ready" screen (1..4095)
- `PLAY_FRAMES`, 1800, frames of gameplay (1..4095)
- `TIMESUP_FRAMES`, 180, frames of the "time's up" screen (1..4095)
- `iVGA_CLK` in 1: pixel clock; the only clock
- `iRST_n` in 1: reset, asynchronous and active-low
- `iVS` in 1: active-low vertical sync from the sync generator, synchronous to `iVGA_CLK`
- `start` in 1: start/continue request, level, any width ≥1 cycle
- `house` in 4: {G,S,H,R} one-hot house select
- `score_inc` in 1: one-cycle pulse, +1 point
- `logo`, `get_ready`, `times_up`, `leaderboard` out 1 each: screen flags, registered
- `playing` out 1: high in PLAY
- `frames_left` out 12: frames remaining in the current timed phase
- `score_bcd` out 16: {thousands, hundreds, tens, ones} current score
- `best_bcd` out 16: best score since reset
- `best_house` out 4: one-hot house that set `best_bcd`

## Operation
- Frame tick: `vs_d` is a register of `iVS`. The tick is `vs_d & ~iVS`: one cycle per frame, on the first cycle `iVS` is low.
- States:
  - LOGO: `logo`=1.
  - IDLE: all flags 0.
  - READY: `get_ready`=1.
  - PLAY: `playing`=1.
  - TIMESUP: `times_up`=1.
  - LEADER: `leaderboard`=1.
- At most one output flag is high in any cycle.
- Phase counter `fcnt` (12 bits) is cleared on every state change.
- In timed states (LOGO, READY, PLAY, TIMESUP), `fcnt` increments on each tick.
- When a tick arrives with `fcnt == N-1`, the block moves to the next state. N is the parameter for the current state.
- Timed-state sequence: LOGO→IDLE, READY→PLAY, PLAY→TIMESUP, TIMESUP→LEADER.
- `frames_left` = N − `fcnt` in timed states, 0 otherwise.
- Start latch:
  - In IDLE or LEADER, `start`=1 sets `start_pend` only if `house` has exactly one bit set.
  - A `start` with an invalid `house` is ignored.
  - `start` in any other state is ignored and never latched.
- Tick with `start_pend`=1 takes the start transition and clears `start_pend`:
  - IDLE→READY.
  - LEADER→IDLE.
- READY entry: `score_bcd` ← 0 and the one-hot `house` is captured as `cur_house`.
- Score:
  - In PLAY, each `score_inc` adds 1 in BCD with digit carry.
  - The score saturates at 9999; further pulses are ignored.
  - `score_inc` outside PLAY is ignored.
- A `score_inc` in the PLAY cycle that also carries the PLAY→TIMESUP tick is counted.
- TIMESUP→LEADER transition: if `score_bcd` > `best_bcd` (strict compare), then `best_bcd` ← `score_bcd` and `best_house` ← `cur_house`. On a tie the old best is kept.
- `score_bcd` keeps its value through TIMESUP, LEADER and IDLE.

## Timing
- Reset (async, `iRST_n`=0):
  - State is LOGO; `logo`=1; all other flags, `playing`, `start_pend` and `fcnt` are 0.
  - `frames_left`=`LOGO_FRAMES`.
  - `score_bcd`, `best_bcd` and `best_house` are 0.
  - `vs_d`=1, so a low `iVS` at release gives a tick on the first clock.
- Reset mid-game returns to LOGO and loses the best score.
- Tick-to-output latency: state and flags update on the clock edge that ends the tick cycle. Flags change exactly 1 cycle after `iVS` is first seen low.
- Score latency: `score_bcd` updates on the edge after the `score_inc` cycle. Back-to-back pulses each count.
- `start` sampled in a tick cycle:
  - It is latched but does not move the state on that tick.
  - The transition happens on the next tick.
- `iVS` held low gives only one tick; a new tick needs `iVS` high for ≥1 cycle.

## Test plan
- Reset with all phase parameters = 2 and `iVS` toggling every 10 cycles:
  - `logo`=1 for 2 ticks, then all flags 0 (IDLE).
  - Flag change lands 1 cycle after each `iVS` fall.
- In IDLE:
  - `start`=1 with `house`=4'b0000 or 4'b0101 → no READY after 3 ticks.
  - `start`=1 with `house`=4'b1000 → READY on the next tick.
  - READY → `get_ready`=1 for 2 ticks, then PLAY.
- In PLAY, 12 `score_inc` pulses including back-to-back ones → `score_bcd`=16'h0012.
  - A pulse in the final tick cycle counts: 13 pulses → 16'h0013.
  - After 2 ticks → `times_up`=1.
- Saturation: preload via 9999 pulses (or force) → `score_bcd`=16'h9999; one more pulse → stays 16'h9999.
- Best score:
  - Game 1 scores 5 with house G → at LEADER, `best_bcd`=16'h0005 and `best_house`=4'b1000.
  - Game 2 scores 5 with house S → best unchanged.
  - Game 3 scores 7 with house S → `best_bcd`=16'h0007 and `best_house`=4'b0100.
- `start` pulsed in LOGO/READY/PLAY/TIMESUP → sequence timing unchanged. Assert async reset mid-PLAY → `logo`=1 and all scores 0 immediately, without a clock.

Source files
------------

// File: rtl/screen_sequencer.sv
// Game-phase controller on the VGA pixel clock: sequences logo/ready/play/time's-up/leaderboard
// screens on frame boundaries and tracks the BCD score and best score with its house.
module screen_sequencer #(
  parameter int LOGO_FRAMES    = 300,
  parameter int READY_FRAMES   = 180,
  parameter int PLAY_FRAMES    = 1800,
  parameter int TIMESUP_FRAMES = 180
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        start,
  input  logic [3:0]  house,
  input  logic        score_inc,
  output logic        logo,
  output logic        get_ready,
  output logic        times_up,
  output logic        leaderboard,
  output logic        playing,
  output logic [11:0] frames_left,
  output logic [15:0] score_bcd,
  output logic [15:0] best_bcd,
  output logic [3:0]  best_house
);

  typedef enum logic [2:0] {S_LOGO, S_IDLE, S_READY, S_PLAY, S_TIMESUP, S_LEADER} state_t;

  state_t      r_state, w_next;
  logic        r_vs_d, r_start_pend;
  logic        w_tick, w_timed, w_done, w_take_start, w_start_ok, w_house_ok;
  logic [11:0] r_fcnt, w_n;
  logic [15:0] r_score, r_best;
  logic [3:0]  r_cur_house, r_best_house;
  logic        r_logo, r_get_ready, r_times_up, r_leaderboard, r_playing;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    w_tick  = r_vs_d & ~iVS;
    w_timed = 1'b1;
    w_n     = 12'd0;
    case (r_state)
      S_LOGO:    w_n = 12'(LOGO_FRAMES);
      S_READY:   w_n = 12'(READY_FRAMES);
      S_PLAY:    w_n = 12'(PLAY_FRAMES);
      S_TIMESUP: w_n = 12'(TIMESUP_FRAMES);
      default:   w_timed = 1'b0;
    endcase
    w_done       = w_timed && w_tick && (r_fcnt == w_n - 12'd1);
    w_take_start = !w_timed && w_tick && r_start_pend;
    w_house_ok   = (house != 4'd0) && ((house & (house - 4'd1)) == 4'd0);
    w_start_ok   = start && w_house_ok && (r_state == S_IDLE || r_state == S_LEADER);
    w_next       = r_state;
    case (r_state)
      S_LOGO:    if (w_done)       w_next = S_IDLE;
      S_IDLE:    if (w_take_start) w_next = S_READY;
      S_READY:   if (w_done)       w_next = S_PLAY;
      S_PLAY:    if (w_done)       w_next = S_TIMESUP;
      S_TIMESUP: if (w_done)       w_next = S_LEADER;
      S_LEADER:  if (w_take_start) w_next = S_IDLE;
      default:                     w_next = S_LOGO;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state       <= S_LOGO;
      r_vs_d        <= 1'b1;
      r_fcnt        <= 12'd0;
      r_start_pend  <= 1'b0;
      r_logo        <= 1'b1;
      r_get_ready   <= 1'b0;
      r_times_up    <= 1'b0;
      r_leaderboard <= 1'b0;
      r_playing     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_vs_d        <= iVS;
      if (w_next != r_state)      r_fcnt <= 12'd0;
      else if (w_timed && w_tick) r_fcnt <= r_fcnt + 12'd1;
      // Consuming the pending start wins over a fresh request in the same cycle.
      if (w_take_start)           r_start_pend <= 1'b0;
      else if (w_start_ok)        r_start_pend <= 1'b1;
      r_logo        <= (w_next == S_LOGO);
      r_get_ready   <= (w_next == S_READY);
      r_times_up    <= (w_next == S_TIMESUP);
      r_leaderboard <= (w_next == S_LEADER);
      r_playing     <= (w_next == S_PLAY);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_score      <= 16'd0;
      r_cur_house  <= 4'd0;
      r_best       <= 16'd0;
      r_best_house <= 4'd0;
    end else begin
      if (w_next == S_READY && r_state != S_READY) begin
        r_score     <= 16'd0;
        r_cur_house <= house;
      end else if (r_state == S_PLAY && score_inc && r_score != 16'h9999) begin
        r_score <= bcd_inc(r_score);
      end
      // Packed BCD orders the same as binary, so a plain compare works.
      if (r_state == S_TIMESUP && w_next == S_LEADER && r_score > r_best) begin
        r_best       <= r_score;
        r_best_house <= r_cur_house;
      end
    end
  end

  assign logo        = r_logo;
  assign get_ready   = r_get_ready;
  assign times_up    = r_times_up;
  assign leaderboard = r_leaderboard;
  assign playing     = r_playing;
  assign frames_left = w_timed ? (w_n - r_fcnt) : 12'd0;
  assign score_bcd   = r_score;
  assign best_bcd    = r_best;
  assign best_house  = r_best_house;

endmodule
